// File: rtl/mouse_device_sm_if.sv
// Device-side PS/2 mouse bus: byte receiver/transmitter handshake plus movement source.
// The master modport is the host/BFM side; the slave modport is the mouse responder.
interface mouse_device_sm_if;
  logic       READ_ENABLE;
  logic       BYTE_READY;
  logic [7:0] BYTE_READ;
  logic [1:0] BYTE_ERROR_CODE;
  logic       SEND_BYTE;
  logic [7:0] BYTE_TO_SEND;
  logic       BYTE_SENT;
  logic       MOVE_VALID;
  logic [7:0] MOVE_STATUS;
  logic [7:0] MOVE_DX;
  logic [7:0] MOVE_DY;
  logic [7:0] MOVE_DZ;
  logic       MOVE_ACCEPT;
  logic       STREAM_EN;
  logic       INTELLI_MODE;
  logic [7:0] SAMPLE_RATE;

  modport master (
    input  READ_ENABLE, SEND_BYTE, BYTE_TO_SEND, MOVE_ACCEPT, STREAM_EN, INTELLI_MODE, SAMPLE_RATE,
    output BYTE_READY, BYTE_READ, BYTE_ERROR_CODE, BYTE_SENT,
           MOVE_VALID, MOVE_STATUS, MOVE_DX, MOVE_DY, MOVE_DZ
  );

  modport slave (
    output READ_ENABLE, SEND_BYTE, BYTE_TO_SEND, MOVE_ACCEPT, STREAM_EN, INTELLI_MODE, SAMPLE_RATE,
    input  BYTE_READY, BYTE_READ, BYTE_ERROR_CODE, BYTE_SENT,
           MOVE_VALID, MOVE_STATUS, MOVE_DX, MOVE_DY, MOVE_DZ
  );
endinterface

// File: rtl/mouse_device_sm.sv
// PS/2 mouse device emulator: self-test announce, host command responder,
// and 3/4-byte movement packet streamer with IntelliMouse unlock detection.
module mouse_device_sm #(
  parameter int unsigned SELFTEST_CYCLES = 5000000
) (
  input  logic            CLK,
  input  logic            RESET,
  mouse_device_sm_if.slave bus
);

  typedef enum logic [2:0] {
    POWERUP_WAIT, ANNOUNCE, IDLE, DECODE, RESPOND, WAIT_RATE, PKT_SEND, PKT_GAP
  } state_t;

  localparam logic [31:0] CNT_LAST = 32'(SELFTEST_CYCLES - 1);

  state_t            state, state_n;
  logic [31:0]       cnt, cnt_n;
  logic [2:0][7:0]   q, q_n;
  logic [1:0]        qlen, qlen_n, qidx, qidx_n;
  logic              ret_wait, ret_wait_n;
  logic [3:0][7:0]   pkt, pkt_n;
  logic [1:0]        pcur, pcur_n, plast, plast_n;
  logic              send, send_n, acc, acc_n;
  logic [7:0]        tx, tx_n;
  logic              stream, stream_n, intelli, intelli_n;
  logic [7:0]        rate, rate_n;
  logic [1:0]        match, match_n;
  logic [7:0]        cmd, cmd_n;
  logic              err, err_n, in_rate, in_rate_n;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state <= POWERUP_WAIT; cnt <= '0; q <= '0; qlen <= '0; qidx <= '0;
      ret_wait <= 1'b0; pkt <= '0; pcur <= '0; plast <= '0;
      send <= 1'b0; acc <= 1'b0; tx <= 8'h00;
      stream <= 1'b0; intelli <= 1'b0; rate <= 8'h64; match <= '0;
      cmd <= '0; err <= 1'b0; in_rate <= 1'b0;
    end else begin
      state <= state_n; cnt <= cnt_n; q <= q_n; qlen <= qlen_n; qidx <= qidx_n;
      ret_wait <= ret_wait_n; pkt <= pkt_n; pcur <= pcur_n; plast <= plast_n;
      send <= send_n; acc <= acc_n; tx <= tx_n;
      stream <= stream_n; intelli <= intelli_n; rate <= rate_n; match <= match_n;
      cmd <= cmd_n; err <= err_n; in_rate <= in_rate_n;
    end
  end

  always_comb begin
    state_n = state; cnt_n = cnt; q_n = q; qlen_n = qlen; qidx_n = qidx;
    ret_wait_n = ret_wait; pkt_n = pkt; pcur_n = pcur; plast_n = plast;
    send_n = 1'b0; acc_n = 1'b0; tx_n = tx;
    stream_n = stream; intelli_n = intelli; rate_n = rate; match_n = match;
    cmd_n = cmd; err_n = err; in_rate_n = in_rate;

    case (state)
      POWERUP_WAIT: begin
        if (cnt == CNT_LAST) begin
          state_n = ANNOUNCE; q_n = {8'h00, 8'h00, 8'hAA};
          qlen_n = 2'd2; qidx_n = 2'd1; ret_wait_n = 1'b0;
          send_n = 1'b1; tx_n = 8'hAA;
        end else begin
          cnt_n = cnt + 32'd1;
        end
      end
      // Announce and command responses share the same byte-queue drain.
      ANNOUNCE, RESPOND: begin
        if (bus.BYTE_SENT) begin
          if (qidx == qlen) begin
            state_n = ret_wait ? WAIT_RATE : IDLE;
          end else begin
            send_n = 1'b1; tx_n = q[qidx]; qidx_n = qidx + 2'd1;
          end
        end
      end
      IDLE: begin
        if (bus.BYTE_READY) begin
          cmd_n = bus.BYTE_READ; err_n = |bus.BYTE_ERROR_CODE;
          in_rate_n = 1'b0; state_n = DECODE;
        end else if (bus.MOVE_VALID) begin
          acc_n = 1'b1;
          if (stream) begin
            pkt_n = {bus.MOVE_DZ, bus.MOVE_DY, bus.MOVE_DX, bus.MOVE_STATUS | 8'h08};
            pcur_n = 2'd0; plast_n = intelli ? 2'd3 : 2'd2;
            send_n = 1'b1; tx_n = bus.MOVE_STATUS | 8'h08; state_n = PKT_SEND;
          end
        end
      end
      WAIT_RATE: begin
        if (bus.BYTE_READY) begin
          cmd_n = bus.BYTE_READ; err_n = |bus.BYTE_ERROR_CODE;
          in_rate_n = 1'b1; state_n = DECODE;
        end
      end
      PKT_SEND: begin
        if (bus.BYTE_SENT) state_n = (pcur == plast) ? IDLE : PKT_GAP;
      end
      PKT_GAP: begin
        // A host byte here abandons the remainder of the packet for good.
        if (bus.BYTE_READY) begin
          cmd_n = bus.BYTE_READ; err_n = |bus.BYTE_ERROR_CODE;
          in_rate_n = 1'b0; state_n = DECODE;
        end else begin
          pcur_n = pcur + 2'd1; send_n = 1'b1; tx_n = pkt[pcur_n]; state_n = PKT_SEND;
        end
      end
      DECODE: begin
        state_n = RESPOND; qidx_n = 2'd1; qlen_n = 2'd1;
        ret_wait_n = 1'b0; q_n = {8'h00, 8'h00, 8'hFA};
        if (err) begin
          q_n[0] = 8'hFE; ret_wait_n = in_rate;
        end else if (in_rate && cmd != 8'hFF) begin
          rate_n = cmd;
          if (cmd == 8'hC8)                       match_n = 2'd1;
          else if (cmd == 8'h64 && match == 2'd1) match_n = 2'd2;
          else if (cmd == 8'h50 && match == 2'd2) begin match_n = 2'd0; intelli_n = 1'b1; end
          else                                    match_n = 2'd0;
        end else begin
          case (cmd)
            8'hFF: begin
              q_n = {8'h00, 8'hAA, 8'hFA}; qlen_n = 2'd3;
              stream_n = 1'b0; intelli_n = 1'b0; match_n = 2'd0; rate_n = 8'h64;
            end
            8'hF6: begin stream_n = 1'b0; rate_n = 8'h64; match_n = 2'd0; end
            8'hF5: begin stream_n = 1'b0; match_n = 2'd0; end
            8'hF4: begin stream_n = 1'b1; match_n = 2'd0; end
            8'hF3: ret_wait_n = 1'b1;
            8'hF2: begin
              q_n[1] = intelli ? 8'h03 : 8'h00; qlen_n = 2'd2; match_n = 2'd0;
            end
            default: q_n[0] = 8'hFE;
          endcase
        end
        send_n = 1'b1; tx_n = q_n[0];
      end
      default: state_n = POWERUP_WAIT;
    endcase
  end

  assign bus.READ_ENABLE  = (state == IDLE) || (state == WAIT_RATE) || (state == PKT_GAP);
  assign bus.SEND_BYTE    = send;
  assign bus.BYTE_TO_SEND = tx;
  assign bus.MOVE_ACCEPT  = acc;
  assign bus.STREAM_EN    = stream;
  assign bus.INTELLI_MODE = intelli;
  assign bus.SAMPLE_RATE  = rate;

endmodule

// File: tb/tb_mouse_device_sm.sv
// Scoreboard bench for mouse_device_sm: stimulus pushes expected transmitted
// bytes, an independent monitor pops and compares on every SEND_BYTE pulse.
module tb_mouse_device_sm;
  logic CLK = 1'b0;
  logic RESET = 1'b0;
  mouse_device_sm_if bus();

  mouse_device_sm #(.SELFTEST_CYCLES(20)) dut (.CLK(CLK), .RESET(RESET), .bus(bus));

  always #5 CLK = ~CLK;

  int tests = 0, fails = 0, acc_cnt = 0, pend = -1;
  logic [7:0] exp_q[$];
  logic busy = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Transmitter model: BYTE_SENT pulse a few cycles after each SEND_BYTE.
  initial begin
    bus.BYTE_SENT = 1'b0;
    forever begin
      @(posedge CLK); #1;
      bus.BYTE_SENT = 1'b0;
      if (!RESET) pend = -1;
      else if (pend == 0) begin bus.BYTE_SENT = 1'b1; pend = -1; end
      else if (pend > 0) pend--;
      if (RESET && bus.SEND_BYTE) pend = 2;
    end
  end

  // Monitor: compare every transmitted byte against the scoreboard.
  initial begin
    forever begin
      @(negedge CLK);
      if (!RESET) busy = 1'b0;
      else begin
        if (bus.BYTE_SENT) busy = 1'b0;
        if (bus.MOVE_ACCEPT) acc_cnt++;
        if (bus.SEND_BYTE) begin
          if (busy) begin
            tests++; fails++;
            $display("FAIL send_overlap: SEND_BYTE reasserted before BYTE_SENT");
          end
          busy = 1'b1;
          if (exp_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL tx_unexpected: got %0h expected nothing", bus.BYTE_TO_SEND);
          end else chk("tx_byte", {24'h0, bus.BYTE_TO_SEND}, {24'h0, exp_q.pop_front()});
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

  task automatic host_byte(input logic [7:0] b, input logic [1:0] ec = 2'b00);
    logic s1;
    int n = 0;
    @(posedge CLK); #1;
    while (!bus.READ_ENABLE && n < 200) begin @(posedge CLK); #1; n++; end
    if (n >= 200) chk("read_enable_timeout", 0, 1);
    bus.BYTE_READY = 1'b1; bus.BYTE_READ = b; bus.BYTE_ERROR_CODE = ec;
    @(posedge CLK); #1;
    bus.BYTE_READY = 1'b0; bus.BYTE_ERROR_CODE = 2'b00;
    s1 = bus.SEND_BYTE;
    @(posedge CLK); #1;
    chk("decode_latency", {30'h0, s1, bus.SEND_BYTE}, 32'h1);
  endtask

  task automatic drain();
    int n = 0;
    while (n < 300 && !(exp_q.size() == 0 && pend == -1 && bus.READ_ENABLE)) begin
      @(posedge CLK); #1; n++;
    end
    if (n >= 300) chk("drain_timeout", 0, 1);
  endtask

  task automatic cmd(input logic [7:0] b, input logic [7:0] r0, input int nr = 1,
                     input logic [7:0] r1 = 8'h00, input logic [7:0] r2 = 8'h00);
    exp_q.push_back(r0);
    if (nr > 1) exp_q.push_back(r1);
    if (nr > 2) exp_q.push_back(r2);
    host_byte(b);
    drain();
  endtask

  task automatic move(input logic [7:0] st, dx, dy, dz);
    int n = 0;
    bus.MOVE_STATUS = st; bus.MOVE_DX = dx; bus.MOVE_DY = dy; bus.MOVE_DZ = dz;
    bus.MOVE_VALID = 1'b1;
    @(posedge CLK); #1;
    while (!bus.MOVE_ACCEPT && n < 300) begin @(posedge CLK); #1; n++; end
    if (n >= 300) chk("accept_timeout", 0, 1);
    bus.MOVE_VALID = 1'b0;
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_send"}, {31'h0, bus.SEND_BYTE}, 0);
    chk({nm, "_tx"}, {24'h0, bus.BYTE_TO_SEND}, 0);
    chk({nm, "_re"}, {31'h0, bus.READ_ENABLE}, 0);
    chk({nm, "_acc"}, {31'h0, bus.MOVE_ACCEPT}, 0);
    chk({nm, "_flags"}, {30'h0, bus.STREAM_EN, bus.INTELLI_MODE}, 0);
    chk({nm, "_rate"}, {24'h0, bus.SAMPLE_RATE}, 32'h64);
  endtask

  task automatic powerup();
    exp_q.push_back(8'hAA); exp_q.push_back(8'h00);
    @(negedge CLK); RESET = 1'b1;
    for (int i = 1; i <= 19; i++) begin
      @(posedge CLK); #1;
      bus.BYTE_READY = (i == 5); bus.BYTE_READ = 8'hF4;
    end
    bus.BYTE_READY = 1'b0;
    chk("announce_early", {31'h0, bus.SEND_BYTE}, 0);
    @(posedge CLK); #1;
    chk("announce_at_20", {23'h0, bus.SEND_BYTE, bus.BYTE_TO_SEND}, {23'h0, 1'b1, 8'hAA});
    chk("re_during_announce", {31'h0, bus.READ_ENABLE}, 0);
    drain();
    chk("re_after_announce", {31'h0, bus.READ_ENABLE}, 1);
    chk("ignored_f4", {31'h0, bus.STREAM_EN}, 0);
  endtask

  initial begin
    int a0;
    bus.BYTE_READY = 1'b0; bus.BYTE_READ = 8'h00; bus.BYTE_ERROR_CODE = 2'b00;
    bus.MOVE_VALID = 1'b0; bus.MOVE_STATUS = 8'h00;
    bus.MOVE_DX = 8'h00; bus.MOVE_DY = 8'h00; bus.MOVE_DZ = 8'h00;
    repeat (3) @(posedge CLK); #1;
    chk_reset_vals("reset");
    powerup();

    cmd(8'hFF, 8'hFA, 3, 8'hAA, 8'h00);
    chk("ff_stream", {31'h0, bus.STREAM_EN}, 0);
    chk("ff_rate", {24'h0, bus.SAMPLE_RATE}, 32'h64);
    cmd(8'hF4, 8'hFA);
    chk("f4_stream", {31'h0, bus.STREAM_EN}, 1);

    // IntelliMouse unlock sequence.
    cmd(8'hF3, 8'hFA); cmd(8'hC8, 8'hFA);
    cmd(8'hF3, 8'hFA); cmd(8'h64, 8'hFA);
    cmd(8'hF3, 8'hFA); cmd(8'h50, 8'hFA);
    cmd(8'hF2, 8'hFA, 2, 8'h03);
    chk("intelli_on", {31'h0, bus.INTELLI_MODE}, 1);
    chk("rate_50", {24'h0, bus.SAMPLE_RATE}, 32'h50);

    a0 = acc_cnt;
    exp_q.push_back(8'h09); exp_q.push_back(8'h05); exp_q.push_back(8'hFB); exp_q.push_back(8'h01);
    move(8'h01, 8'h05, 8'hFB, 8'h01);
    drain();
    chk("pkt4_accepts", acc_cnt - a0, 1);

    cmd(8'hFF, 8'hFA, 3, 8'hAA, 8'h00);
    chk("ff_clears_intelli", {31'h0, bus.INTELLI_MODE}, 0);
    cmd(8'hF4, 8'hFA);
    a0 = acc_cnt;
    exp_q.push_back(8'h09); exp_q.push_back(8'h05); exp_q.push_back(8'hFB);
    move(8'h01, 8'h05, 8'hFB, 8'h01);
    drain();
    chk("pkt3_accepts", acc_cnt - a0, 1);

    // Host F5 in the gap after the first packet byte aborts the packet.
    a0 = acc_cnt;
    exp_q.push_back(8'h09); exp_q.push_back(8'hFA);
    move(8'h01, 8'h05, 8'hFB, 8'h01);
    host_byte(8'hF5);
    drain();
    repeat (20) @(posedge CLK); #1;
    chk("abort_stream", {31'h0, bus.STREAM_EN}, 0);
    move(8'h02, 8'h11, 8'h22, 8'h33);
    repeat (20) @(posedge CLK); #1;
    chk("abort_accepts", acc_cnt - a0, 2);

    // Command wins over a simultaneous movement sample.
    cmd(8'hF4, 8'hFA);
    a0 = acc_cnt;
    exp_q.push_back(8'hFA);
    @(posedge CLK); #1;
    bus.MOVE_VALID = 1'b1; bus.BYTE_READY = 1'b1; bus.BYTE_READ = 8'hF5;
    @(posedge CLK); #1;
    bus.BYTE_READY = 1'b0;
    chk("cmd_wins_no_accept", {31'h0, bus.MOVE_ACCEPT}, 0);
    move(8'h00, 8'h00, 8'h00, 8'h00);
    drain();
    repeat (10) @(posedge CLK); #1;
    chk("cmd_wins_accepts", acc_cnt - a0, 1);

    // Errored and unknown bytes.
    exp_q.push_back(8'hFE); host_byte(8'hF4, 2'b01); drain();
    chk("err_stream", {31'h0, bus.STREAM_EN}, 0);
    cmd(8'hEE, 8'hFE);
    chk("unknown_state", {23'h0, bus.STREAM_EN, bus.SAMPLE_RATE}, 32'h64);
    cmd(8'hF3, 8'hFA);
    exp_q.push_back(8'hFE); host_byte(8'h0A, 2'b10); drain();
    cmd(8'h0A, 8'hFA);
    chk("rate_after_err", {24'h0, bus.SAMPLE_RATE}, 32'h0A);

    // Broken unlock sequence must not enter IntelliMouse mode.
    cmd(8'hF3, 8'hFA); cmd(8'hC8, 8'hFA);
    cmd(8'hF3, 8'hFA); cmd(8'h0A, 8'hFA);
    cmd(8'hF3, 8'hFA); cmd(8'h64, 8'hFA);
    cmd(8'hF3, 8'hFA); cmd(8'h50, 8'hFA);
    cmd(8'hF2, 8'hFA, 2, 8'h00);
    chk("variant_intelli", {31'h0, bus.INTELLI_MODE}, 0);
    cmd(8'hF6, 8'hFA);
    chk("f6_rate", {24'h0, bus.SAMPLE_RATE}, 32'h64);

    // Reset asserted while AA is in flight.
    @(negedge CLK); RESET = 1'b0;
    exp_q.delete();
    exp_q.push_back(8'hAA);
    @(negedge CLK); RESET = 1'b1;
    repeat (20) @(posedge CLK); #1;
    chk("reannounce_send", {31'h0, bus.SEND_BYTE}, 1);
    @(posedge CLK); #3;
    RESET = 1'b0; #1;
    chk_reset_vals("mid_reset");
    repeat (3) @(posedge CLK);
    powerup();

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
